// File: rtl/bit_serial_adder_4b.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_4b
//   Adds two WIDTH-bit unsigned operands one bit per clock, LSB first, using a
//   single full adder and a carry flip-flop. load captures A/B, start launches
//   the serial add, and WIDTH cycles later the result appears on sum with done
//   high. The carry out of the MSB is discarded (result is mod 2^WIDTH).
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   load   in   1      capture A,B into operand registers (wins over start)
//   start  in   1      begin serial addition of the held operands
//   A      in   WIDTH  operand A, unsigned
//   B      in   WIDTH  operand B, unsigned
//   sum    out  WIDTH  registered result, (A+B) mod 2^WIDTH
//   done   out  1      result valid; held until next load/start/reset
// -----------------------------------------------------------------------------
module bit_serial_adder_4b #(
    parameter int WIDTH = 4   // must be >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOADED = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] count;

    // Full adder on the current LSBs plus the next value of the result shift
    // register (new bit enters at the MSB so the LSB-first stream lands in order).
    logic             bit_s;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        // NOTE: every output of an always_comb gets a value on every path
        // (defaults first) so no latch is inferred.
        bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_nxt   = res_sh >> 1;
        res_nxt[WIDTH-1] = bit_s;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the hardware regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            done   <= 1'b0;
        end else if (load) begin
            // Load wins over start and aborts any add in flight.
            op_a   <= A;
            op_b   <= B;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            done   <= 1'b0;
            state  <= S_LOADED;
        end else begin
            case (state)
                S_LOADED, S_DONE: begin
                    // Start from DONE re-adds the operands still held.
                    if (start) begin
                        a_sh   <= op_a;
                        b_sh   <= op_b;
                        res_sh <= '0;
                        carry  <= 1'b0;
                        count  <= '0;
                        done   <= 1'b0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt;
                    carry  <= carry_nxt;
                    count  <= count + CNT_W'(1);
                    if (count == LAST_BIT) begin
                        // Final carry is dropped: wrap-around result.
                        sum   <= res_nxt;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: ;  // S_IDLE: start without loaded operands is ignored
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder_4b.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder_4b
//   Table-driven vectors plus hand-written sequences for load/start priority,
//   abort by load, restart from DONE and asynchronous reset mid-add. Expected
//   sums are pushed to a scoreboard queue on start and popped when done rises.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder_4b;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] sum;
    logic             done;

    bit_serial_adder_4b #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .start (start),
        .A     (A),
        .B     (B),
        .sum   (sum),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of what the DUT holds.
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    bit               m_loaded = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One load edge; with_start also raises start on that same edge.
    // A/B are scrambled afterwards: the held operands must not follow them.
    task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit with_start);
        @(negedge clk);
        load  = 1'b1;
        start = with_start;
        A     = a;
        B     = b;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        m_a      = a;
        m_b      = b;
        m_loaded = 1'b1;
        sb.delete();   // a load discards anything in flight
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (m_loaded) sb.push_back(WIDTH'(m_a + m_b));
    endtask

    // Called at the negedge right after the start edge; done must appear
    // after exactly WIDTH more edges.
    task automatic expect_result(input string name);
        int cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, cyc, WIDTH);
        check({name, " queued"}, sb.size(), 1);
        if (sb.size() > 0) check({name, " sum"}, sum, sb.pop_front());
    endtask

    task automatic expect_idle(input string name, input int n);
        repeat (n) @(negedge clk);
        check({name, " no done"}, done, 1'b0);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{a: 4'd3,  b: 4'd5,  exp: 4'd8};
        vecs[1] = '{a: 4'd15, b: 4'd1,  exp: 4'd0};
        vecs[2] = '{a: 4'd9,  b: 4'd7,  exp: 4'd0};
        vecs[3] = '{a: 4'd6,  b: 4'd6,  exp: 4'd12};
        vecs[4] = '{a: 4'd15, b: 4'd15, exp: 4'd14};
        vecs[5] = '{a: 4'd0,  b: 4'd0,  exp: 4'd0};

        rst_n = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset sum", sum, 0);
        check("reset done", done, 0);

        // Start with nothing loaded is ignored.
        do_start();
        expect_idle("start before load", 6);

        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].a, vecs[i].b, 1'b0);
            check($sformatf("vec%0d sum after load", i), sum, 0);
            do_start();
            expect_result($sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), sum, vecs[i].exp);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d done held", i), done, 1'b1);
            check($sformatf("vec%0d sum held", i), sum, vecs[i].exp);
        end

        // load and start on the same edge: load wins, no add.
        do_load(4'd10, 4'd3, 1'b1);
        expect_idle("load+start", 6);
        do_start();
        expect_result("start after load+start");

        // Start from DONE re-adds the held operands.
        do_start();
        expect_result("restart from done");

        // Abort: second load lands on the second RUN edge.
        do_load(4'd2, 4'd3, 1'b0);
        do_start();
        do_load(4'd4, 4'd4, 1'b0);
        expect_idle("abort", 6);
        do_start();
        expect_result("after abort");

        // Asynchronous reset mid-RUN (sum still shows 8 from the last add).
        do_start();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset sum", sum, 0);
        check("async reset done", done, 0);
        sb.delete();
        m_loaded = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("after reset", 6);
        do_start();
        expect_idle("start after reset", 6);
        check("sum after ignored start", sum, 0);

        do_load(4'd7, 4'd8, 1'b0);
        do_start();
        expect_result("recovery");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
